// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, memory-stage port, stall outputs and memory bus.
// slave = arbiter side, master = core/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ireq;
  logic [ADDR_W-1:0] iaddr;
  logic              ivalid;
  logic [DATA_W-1:0] idata;
  logic              dreq;
  logic              dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dwdata;
  logic              dvalid;
  logic [DATA_W-1:0] drdata;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              bus_err;

  modport slave (
    input  ireq, iaddr,
    input  dreq, dwe, daddr, dwdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output ivalid, idata,
    output dvalid, drdata,
    output stall_if, stall_mem,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output bus_err
  );

  modport master (
    output ireq, iaddr,
    output dreq, dwe, daddr, dwdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  ivalid, idata,
    input  dvalid, drdata,
    input  stall_if, stall_mem,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (I) and mem stage (D),
// one outstanding transaction. Ports: clk, rst_n (async low), bus (mem_arbiter_if.slave).
// Optional: define MEM_ARB_TIMEOUT_EN to abort reads after TIMEOUT WAIT cycles (sets bus_err).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  state_t            stateN;
  logic              ownerD;
  logic              lastD;
  logic              drop;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              ivalidQ;
  logic              dvalidQ;
  logic [DATA_W-1:0] idataQ;
  logic [DATA_W-1:0] drdataQ;

  logic              ownReq;
  logic              grantD;
  logic              grant;
  logic              storeDone;
  logic              resp;
  logic              timeOut;
  logic              timeHit;
  logic [DATA_W-1:0] respData;

  if (TIMEOUT < 1) begin : gBadTimeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  // Alternate after a D grant when fetch is waiting, so loads/stores
  // cannot starve instruction fetch.
  assign grantD   = bus.dreq & ~(lastD & bus.ireq);
  assign ownReq   = ownerD ? bus.dreq : bus.ireq;
  assign respData = bus.mem_rvalid ? bus.mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             busErr;

  assign timeHit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      busErr <= 1'b0;
    end else begin
      if (state != WAIT)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (timeOut)
        busErr <= 1'b1;
    end
  end

  assign bus.bus_err = busErr;
`else
  assign timeHit     = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_comb begin
    stateN    = state;
    grant     = 1'b0;
    storeDone = 1'b0;
    resp      = 1'b0;
    timeOut   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ireq | bus.dreq) begin
          grant  = 1'b1;
          stateN = ISSUE;
        end
      end
      ISSUE: begin
        // A withdrawn request (flush) aborts before acceptance.
        if (!ownReq) begin
          stateN = IDLE;
        end else if (bus.mem_ready) begin
          if (memWe) begin
            storeDone = 1'b1;
            stateN    = IDLE;
          end else begin
            stateN = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          resp   = 1'b1;
          stateN = IDLE;
        end else if (timeHit) begin
          timeOut = 1'b1;
          stateN  = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ownerD   <= 1'b0;
      lastD    <= 1'b0;
      drop     <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ivalidQ  <= 1'b0;
      dvalidQ  <= 1'b0;
      idataQ   <= '0;
      drdataQ  <= '0;
    end else begin
      state   <= stateN;
      ivalidQ <= 1'b0;
      dvalidQ <= 1'b0;
      if (grant) begin
        ownerD  <= grantD;
        lastD   <= grantD;
        drop    <= 1'b0;
        memWe   <= grantD & bus.dwe;
        memAddr <= grantD ? bus.daddr : bus.iaddr;
        if (grantD)
          memWdata <= bus.dwdata;
      end
      // Fetch flushed after acceptance: the response is still consumed.
      if (state == WAIT && !ownerD && !bus.ireq)
        drop <= 1'b1;
      if (storeDone)
        dvalidQ <= 1'b1;
      if (resp | timeOut) begin
        if (ownerD) begin
          dvalidQ <= 1'b1;
          drdataQ <= respData;
        end else if (!drop && bus.ireq) begin
          ivalidQ <= 1'b1;
          idataQ  <= respData;
        end
      end
    end
  end

  assign bus.mem_req   = (state == ISSUE) & ownReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.ivalid    = ivalidQ;
  assign bus.dvalid    = dvalidQ;
  assign bus.idata     = idataQ;
  assign bus.drdata    = drdataQ;
  assign bus.stall_if  = bus.ireq & ~ivalidQ;
  assign bus.stall_mem = bus.dreq & ~dvalidQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Inputs change 1ns after posedge, outputs checked 2ns after posedge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ireq = 0; bus.iaddr = '0;
    bus.dreq = 0; bus.dwe = 0; bus.daddr = '0; bus.dwdata = '0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    // reset state
    tick(); tick(); #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_ivalid", bus.ivalid, 0);
    chk("rst_dvalid", bus.dvalid, 0);
    chk("rst_idata", bus.idata, 0);
    chk("rst_drdata", bus.drdata, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    rst_n = 1;

    // fetch, zero-wait memory
    bus.ireq = 1; bus.iaddr = 32'h40; #1;
    chk("f_c0_stall", bus.stall_if, 1);
    chk("f_c0_req", bus.mem_req, 0);
    tick(); bus.mem_ready = 1; #1;
    chk("f_c1_req", bus.mem_req, 1);
    chk("f_c1_addr", bus.mem_addr, 32'h40);
    chk("f_c1_we", bus.mem_we, 0);
    chk("f_c1_stall", bus.stall_if, 1);
    tick(); bus.mem_ready = 0; bus.mem_rvalid = 1;
    bus.mem_rdata = 32'h00A00093; #1;
    chk("f_c2_req", bus.mem_req, 0);
    chk("f_c2_ivalid", bus.ivalid, 0);
    chk("f_c2_stall", bus.stall_if, 1);
    tick(); bus.ireq = 0; bus.mem_rvalid = 0; #1;
    chk("f_c3_ivalid", bus.ivalid, 1);
    chk("f_c3_idata", bus.idata, 32'h00A00093);
    chk("f_c3_stall", bus.stall_if, 0);
    tick(); #1;
    chk("f_c4_ivalid", bus.ivalid, 0);
    chk("f_c4_idata_hold", bus.idata, 32'h00A00093);

    // D wins first, then alternation
    bus.ireq = 1; bus.iaddr = 32'h44;
    bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h100; #1;
    chk("a_stall_mem", bus.stall_mem, 1);
    tick(); bus.mem_ready = 1; #1;
    chk("a_d1_req", bus.mem_req, 1);
    chk("a_d1_addr", bus.mem_addr, 32'h100);
    tick(); bus.mem_ready = 0; bus.mem_rvalid = 1;
    bus.mem_rdata = 32'h11111111; #1;
    tick(); bus.mem_rvalid = 0; bus.daddr = 32'h104; #1;
    chk("a_d1_dvalid", bus.dvalid, 1);
    chk("a_d1_drdata", bus.drdata, 32'h11111111);
    chk("a_d1_ivalid", bus.ivalid, 0);
    chk("a_d1_stall_mem", bus.stall_mem, 0);
    tick(); bus.mem_ready = 1; #1;
    chk("a_i_req", bus.mem_req, 1);
    chk("a_i_addr", bus.mem_addr, 32'h44);
    chk("a_i_stall_mem", bus.stall_mem, 1);
    tick(); bus.mem_ready = 0; bus.mem_rvalid = 1;
    bus.mem_rdata = 32'h22222222; #1;
    tick(); bus.ireq = 0; bus.mem_rvalid = 0; #1;
    chk("a_i_ivalid", bus.ivalid, 1);
    chk("a_i_idata", bus.idata, 32'h22222222);
    chk("a_i_dvalid", bus.dvalid, 0);
    tick(); bus.mem_ready = 1; #1;
    chk("a_d2_req", bus.mem_req, 1);
    chk("a_d2_addr", bus.mem_addr, 32'h104);
    tick(); bus.mem_ready = 0; bus.mem_rvalid = 1;
    bus.mem_rdata = 32'h33333333; #1;
    tick(); bus.dreq = 0; bus.mem_rvalid = 0; #1;
    chk("a_d2_dvalid", bus.dvalid, 1);
    chk("a_d2_drdata", bus.drdata, 32'h33333333);

    // store with two not-ready cycles
    tick();
    bus.dreq = 1; bus.dwe = 1; bus.daddr = 32'h200;
    bus.dwdata = 32'hDEADBEEF; #1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("s_req_wait", bus.mem_req, 1);
      chk("s_we", bus.mem_we, 1);
      chk("s_addr", bus.mem_addr, 32'h200);
      chk("s_wdata", bus.mem_wdata, 32'hDEADBEEF);
    end
    tick(); bus.mem_ready = 1; #1;
    chk("s_req_acc", bus.mem_req, 1);
    chk("s_dvalid_early", bus.dvalid, 0);
    tick(); bus.mem_ready = 0; bus.dreq = 0; bus.dwe = 0;
    bus.ireq = 1; bus.iaddr = 32'h80; #1;
    chk("s_dvalid", bus.dvalid, 1);
    chk("s_req_done", bus.mem_req, 0);

    // fetch abort in ISSUE (granted in the store's pulse cycle)
    tick(); #1;
    chk("ab_req", bus.mem_req, 1);
    chk("ab_addr", bus.mem_addr, 32'h80);
    bus.ireq = 0; #1;
    chk("ab_req_drop", bus.mem_req, 0);
    tick(); #1;
    chk("ab_req_idle", bus.mem_req, 0);
    chk("ab_ivalid", bus.ivalid, 0);
    tick(); #1;
    chk("ab_ivalid2", bus.ivalid, 0);

    // fetch dropped in WAIT, pending load served afterwards
    bus.ireq = 1; bus.iaddr = 32'h84;
    tick(); bus.mem_ready = 1; #1;
    chk("dw_req", bus.mem_req, 1);
    tick(); bus.mem_ready = 0; bus.ireq = 0;
    bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h300; #1;
    chk("dw_wait_req", bus.mem_req, 0);
    chk("dw_stall_mem", bus.stall_mem, 1);
    tick(); bus.mem_rvalid = 1; bus.mem_rdata = 32'h55555555; #1;
    chk("dw_wait_req2", bus.mem_req, 0);
    tick(); bus.mem_rvalid = 0; #1;
    chk("dw_ivalid", bus.ivalid, 0);
    chk("dw_idata_hold", bus.idata, 32'h22222222);
    tick(); bus.mem_ready = 1; #1;
    chk("dw_d_req", bus.mem_req, 1);
    chk("dw_d_addr", bus.mem_addr, 32'h300);

    // unanswered load
    tick(); bus.mem_ready = 0; #1;
    for (int i = 1; i <= 15; i++) begin
      tick(); #1;
      chk("to_dvalid_wait", bus.dvalid, 0);
      chk("to_req_wait", bus.mem_req, 0);
    end
    tick(); #1;
`ifdef MEM_ARB_TIMEOUT_EN
    chk("to_dvalid", bus.dvalid, 1);
    chk("to_drdata", bus.drdata, 0);
    chk("to_bus_err", bus.bus_err, 1);
    bus.dreq = 0;
    tick(); tick(); bus.mem_rvalid = 1; bus.mem_rdata = 32'h66666666; #1;
    tick(); bus.mem_rvalid = 0; #1;
    chk("to_late_dvalid", bus.dvalid, 0);
    chk("to_bus_err_sticky", bus.bus_err, 1);
    bus.dreq = 1; bus.daddr = 32'h400;
    tick(); bus.mem_ready = 1; #1;
    chk("to_req2", bus.mem_req, 1);
    tick(); bus.mem_ready = 0; #1;
`else
    chk("nt_dvalid", bus.dvalid, 0);
    chk("nt_bus_err", bus.bus_err, 0);
    chk("nt_stall_mem", bus.stall_mem, 1);
    tick(); tick(); #1;
    chk("nt_dvalid2", bus.dvalid, 0);
    chk("nt_req", bus.mem_req, 0);
`endif

    // async reset during WAIT
    rst_n = 0; bus.dreq = 0; #1;
    chk("ar_mem_addr", bus.mem_addr, 0);
    chk("ar_mem_wdata", bus.mem_wdata, 0);
    chk("ar_mem_we", bus.mem_we, 0);
    chk("ar_idata", bus.idata, 0);
    chk("ar_drdata", bus.drdata, 0);
    chk("ar_bus_err", bus.bus_err, 0);
    chk("ar_mem_req", bus.mem_req, 0);
    tick(); rst_n = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77777777; #1;
    tick(); bus.mem_rvalid = 0; #1;
    chk("ar_late_dvalid", bus.dvalid, 0);
    chk("ar_late_ivalid", bus.ivalid, 0);
    chk("ar_late_drdata", bus.drdata, 0);
    chk("ar_late_req", bus.mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port instruction/data memory between the fetch stage and the memory stage of the 5-stage pipelined core. It sequences every access through a request/accept/response handshake and returns read data or write completion to the requester. It also drives per-port stall requests into the hazard logic. At most one memory transaction is outstanding at any time.

## Interface
- ADDR_W, 32, address width of both ports and memory
- DATA_W, 32, data width
- TIMEOUT, 16, maximum WAIT cycles before a read is aborted (used only with the timeout feature)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ireq  in  1  fetch read request, held until ivalid or withdrawn
- iaddr  in  ADDR_W  fetch address, stable while ireq
- ivalid  out  1  one-cycle pulse, idata valid
- idata  out  DATA_W  fetched instruction word
- dreq  in  1  memory-stage request, held until dvalid
- dwe  in  1  1 = store, 0 = load; stable while dreq
- daddr  in  ADDR_W  data address
- dwdata  in  DATA_W  store data
- dvalid  out  1  one-cycle pulse: load data valid or store complete
- drdata  out  DATA_W  load data
- stall_if  out  1  ireq & ~ivalid (combinational)
- stall_mem  out  1  dreq & ~dvalid (combinational)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts when mem_req & mem_ready
- mem_rvalid  in  1  read response valid, only for reads, in order
- mem_rdata  in  DATA_W  read response data
- bus_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ISSUE, WAIT. Registers: owner (I/D), last_d, drop flag.
- IDLE: if any request is pending, pick an owner, latch its address, data and we, then go to ISSUE.
- Arbitration: D wins over I, except when last_d=1 and ireq=1, in which case I wins. last_d records the owner of the previous grant. This prevents fetch starvation across back-to-back loads/stores.
- ISSUE: mem_req=1, driven from the latched fields. On mem_ready:
  - store: go to IDLE and pulse dvalid the next cycle.
  - load/fetch: go to WAIT.
- ISSUE abort: if the owner drops its req before acceptance (branch flush), deassert mem_req the same cycle, go to IDLE, and issue no pulse.
- WAIT: on mem_rvalid, register mem_rdata into idata/drdata, pulse the owner's valid, and go to IDLE.
  - If ireq dropped after acceptance, set drop. The response is consumed but no ivalid is pulsed.
  - A new ireq during WAIT waits for IDLE.
- idata/drdata hold their last value between pulses.
- mem_req is 0 in IDLE and WAIT. mem_addr, mem_we and mem_wdata hold the latched values.

## Timing
- Reset values: state IDLE, ivalid=dvalid=0, idata=drdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, last_d=0, bus_err=0.
- Request seen in IDLE at cycle 0 gives mem_req at cycle 1.
- Read with zero wait: mem_ready at cycle 1, mem_rvalid at cycle 2, valid pulse at cycle 3. Minimum read latency is 3 cycles.
- Store with mem_ready at cycle 1 pulses dvalid at cycle 2.
- The next grant can be made in the IDLE cycle that coincides with a valid pulse. Back-to-back read throughput is 1 per 3 cycles.
- Reset mid-transaction: immediate return to IDLE, outputs go to reset values, and any in-flight response is ignored.
- Simultaneous ireq and dreq in IDLE with last_d=0: D is granted.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no mem_rvalid: pulse the owner's valid with data 0, set bus_err (cleared only by rst_n), and return to IDLE.
  - A late mem_rvalid arriving in IDLE is ignored.
- Undefined: no counter, bus_err tied 0, WAIT persists indefinitely, TIMEOUT unused.

## Test plan
- Reset release, ireq=1, iaddr=0x40, mem_ready=1, rvalid one cycle after accept with data 0x00A00093 -> mem_req at cycle 1, ivalid at cycle 3, idata=0x00A00093, stall_if high cycles 0-2.
- ireq and dreq (load 0x100) both asserted -> D served first, then I. Then dreq held again with ireq -> I served before the second D (alternation).
- Store daddr=0x200, dwdata=0xDEADBEEF, mem_ready low 2 cycles -> mem_req held 3 cycles with stable fields, dvalid the cycle after acceptance, no WAIT.
- ireq dropped in ISSUE before mem_ready -> mem_req falls the same cycle, no ivalid. ireq dropped in WAIT -> response consumed, no ivalid, next request granted in the following IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=16, a load never answered -> dvalid with drdata=0 after 16 WAIT cycles, bus_err=1 until rst_n. Without the macro, the FSM stays in WAIT and bus_err=0.
- rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously, and a subsequent mem_rvalid produces no pulse.
